ebus_ctl: RTL and testbench

EBOX-side EBUS transaction sequencer. It accepts one I/O request at a time from the EBOX microcode-facing logic (CONO, CONI, DATAO, DATAI, PI-served, PI-address-in) and sequences the EBUS controller-select, function, demand and data-drive signals. It waits for the device's transfer handshake or a timeout, then returns captured data and status. It is the single EBOX owner of the EBUS control lines; its data output is one `tEBUSdriver` slot on the EBUS data mux. It also sequences EBUS reset pulses.

---
 rtl/ebus_ctl.sv | 182 ++++++++++++++++++
 tb/tb_ebus_ctl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebus_ctl.sv
// ebus_ctl: EBOX-side EBUS transaction sequencer and EBUS reset pulser.
// Ports: clk/CROBAR; req* request in, done* completion out; ebus* bus control; drv data-mux slot.
//
// Function codes (tEBUSfunction):
//   000 CONO, 001 CONI, 010 DATAO, 011 DATAI, 100 PI served, 101 PI addr in,
//   110 and 111 are undefined and complete as a timed-out no-op.
// drv packs {driving, data[35:0]}, with driving in bit 36.
module ebus_ctl #(
  parameter int TIMEOUT      = 64,
  parameter int RESET_CYCLES = 8
) (
  input  logic        clk,
  input  logic        CROBAR,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [2:0]  reqFunc,
  input  logic [6:0]  reqCS,
  input  logic [35:0] reqData,
  output logic        done,
  output logic [35:0] doneData,
  output logic        doneTimeout,
  input  logic        resetReq,
  output logic [6:0]  ebusCS,
  output logic [2:0]  ebusFunc,
  output logic        ebusDemand,
  output logic        ebusReset,
  input  logic        ebusXfer,
  input  logic [35:0] ebusDataIn,
  output logic [36:0] drv
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);

  localparam logic [2:0] F_CONO   = 3'd0;
  localparam logic [2:0] F_CONI   = 3'd1;
  localparam logic [2:0] F_DATAO  = 3'd2;
  localparam logic [2:0] F_DATAI  = 3'd3;
  localparam logic [2:0] F_PIADDR = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_DEMAND,
    S_RELEASE,
    S_DONE,
    S_RESET
  } state_e;

  typedef struct packed {
    logic        driving;
    logic [35:0] data;
  } drv_t;

  state_e        state_q;
  logic [6:0]    cs_q;
  logic [2:0]    func_q;
  logic          demand_q;
  logic          reset_q;
  drv_t          drv_q;
  logic [35:0]   rdata_q;
  logic          tmo_q;
  logic [5:0]    cnt_q;
  logic [RW-1:0] rcnt_q;
  logic          done_q;
  logic [35:0]   done_data_q;
  logic          done_tmo_q;

  function automatic logic is_wr(input logic [2:0] f);
    return (f == F_CONO) || (f == F_DATAO);
  endfunction

  function automatic logic is_rd(input logic [2:0] f);
    return (f == F_CONI) || (f == F_DATAI) || (f == F_PIADDR);
  endfunction

  assign reqReady    = (state_q == S_IDLE);
  assign done        = done_q;
  assign doneData    = done_data_q;
  assign doneTimeout = done_tmo_q;
  assign ebusCS      = cs_q;
  assign ebusFunc    = func_q;
  assign ebusDemand  = demand_q;
  assign ebusReset   = reset_q;
  assign drv         = drv_q;

  // cs_q/func_q double as the request latches; every output register is
  // loaded on the transition into the state it belongs to.
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state_q     <= S_IDLE;
      cs_q        <= '0;
      func_q      <= '0;
      demand_q    <= 1'b0;
      reset_q     <= 1'b0;
      drv_q       <= '0;
      rdata_q     <= '0;
      tmo_q       <= 1'b0;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      done_q      <= 1'b0;
      done_data_q <= '0;
      done_tmo_q  <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      done_data_q <= '0;
      done_tmo_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (resetReq) begin
            state_q <= S_RESET;
            reset_q <= 1'b1;
            rcnt_q  <= '0;
          end else if (reqValid) begin
            state_q       <= S_SETUP;
            cs_q          <= reqCS;
            func_q        <= reqFunc;
            drv_q.driving <= is_wr(reqFunc);
            drv_q.data    <= is_wr(reqFunc) ? reqData : '0;
            rdata_q       <= '0;
            tmo_q         <= 1'b0;
            cnt_q         <= '0;
          end
        end
        S_SETUP: begin
          if (func_q[2] && func_q[1]) begin
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            done_tmo_q <= 1'b1;
            cs_q       <= '0;
            func_q     <= '0;
            drv_q      <= '0;
          end else begin
            state_q  <= S_DEMAND;
            demand_q <= 1'b1;
          end
        end
        S_DEMAND: begin
          // Saturate so a long stall can never wrap back to zero.
          if (cnt_q != 6'h3f) cnt_q <= cnt_q + 6'd1;
          if (ebusXfer) begin
            if (is_rd(func_q)) rdata_q <= ebusDataIn;
            demand_q <= 1'b0;
            state_q  <= S_RELEASE;
          end else if (cnt_q == TMO_LAST) begin
            tmo_q    <= 1'b1;
            rdata_q  <= '0;
            demand_q <= 1'b0;
            state_q  <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (tmo_q || !ebusXfer) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            done_data_q <= rdata_q;
            done_tmo_q  <= tmo_q;
            cs_q        <= '0;
            func_q      <= '0;
            drv_q       <= '0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        S_RESET: begin
          if (rcnt_q == RST_LAST) begin
            reset_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ebus_ctl.sv
// tb_ebus_ctl: vector table, random transactions vs. a transaction-level model,
// plus hand sequences for EBUS reset, CROBAR abort and back-to-back requests.
module tb_ebus_ctl;

  localparam int TMO = 64;
  localparam int RSTC = 8;

  logic        clk = 1'b0;
  logic        CROBAR;
  logic        reqValid;
  logic        reqReady;
  logic [2:0]  reqFunc;
  logic [6:0]  reqCS;
  logic [35:0] reqData;
  logic        done;
  logic [35:0] doneData;
  logic        doneTimeout;
  logic        resetReq;
  logic [6:0]  ebusCS;
  logic [2:0]  ebusFunc;
  logic        ebusDemand;
  logic        ebusReset;
  logic        ebusXfer;
  logic [35:0] ebusDataIn;
  logic [36:0] drv;

  int checks = 0;
  int errors = 0;

  ebus_ctl #(.TIMEOUT(TMO), .RESET_CYCLES(RSTC)) dut (
    .clk(clk), .CROBAR(CROBAR),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqFunc(reqFunc), .reqCS(reqCS), .reqData(reqData),
    .done(done), .doneData(doneData), .doneTimeout(doneTimeout),
    .resetReq(resetReq),
    .ebusCS(ebusCS), .ebusFunc(ebusFunc),
    .ebusDemand(ebusDemand), .ebusReset(ebusReset),
    .ebusXfer(ebusXfer), .ebusDataIn(ebusDataIn),
    .drv(drv)
  );

  always #5 clk = ~clk;

  // k: DEMAND cycle (1-based) in which the device raises xfer, 0 = never.
  // h: RELEASE cycles the device keeps xfer high after demand drops.
  typedef struct {
    logic [2:0]  f;
    logic [6:0]  cs;
    logic [35:0] wd;
    int          k;
    int          h;
    logic [35:0] dv;
    int          lat;
    int          dem;
    int          drvc;
    logic [35:0] dd;
    logic        tmo;
  } vec_t;

  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t r;
    int rel;
    logic wr;
    logic rd;
    r = v;
    wr = (v.f == 3'd0) || (v.f == 3'd2);
    rd = (v.f == 3'd1) || (v.f == 3'd3) || (v.f == 3'd5);
    if (v.f >= 3'd6) begin
      r.lat = 2; r.dem = 0; r.drvc = 0; r.dd = '0; r.tmo = 1'b1;
    end else begin
      r.tmo  = (v.k < 1) || (v.k > TMO);
      r.dem  = r.tmo ? TMO : v.k;
      rel    = r.tmo ? 1 : v.h + 1;
      r.lat  = 1 + r.dem + rel + 1;
      r.drvc = wr ? 1 + r.dem + rel : 0;
      r.dd   = (rd && !r.tmo) ? v.dv : 36'd0;
    end
    return r;
  endfunction

  task automatic run_txn(input vec_t v, output int lat, output int dem,
                         output int drvc, output logic [35:0] dd,
                         output logic tmo, output logic hold_ok);
    int c;
    int relhi;
    logic fin;
    logic [63:0] g;
    c = 0; relhi = 0; fin = 1'b0;
    lat = -1; dem = 0; drvc = 0; dd = '0; tmo = 1'b0; hold_ok = 1'b1;
    reqFunc = v.f; reqCS = v.cs; reqData = v.wd; reqValid = 1'b1;
    tick();
    reqValid = 1'b0;
    g = {$urandom, $urandom};
    reqData = g[35:0];
    while (!fin && c < 200) begin
      c++;
      if (done) begin
        fin = 1'b1; lat = c; dd = doneData; tmo = doneTimeout;
        if (ebusCS != 0 || ebusFunc != 0 || drv != 0 || ebusDemand)
          hold_ok = 1'b0;
        ebusXfer = 1'b0;
      end else begin
        if (ebusCS !== v.cs || ebusFunc !== v.f) hold_ok = 1'b0;
        if (ebusDemand) dem++;
        if (drv[36]) begin
          drvc++;
          if (drv[35:0] !== v.wd) hold_ok = 1'b0;
        end else if (drv[35:0] !== 36'd0) begin
          hold_ok = 1'b0;
        end
        if (ebusDemand && dem == v.k) begin
          ebusXfer = 1'b1;
          ebusDataIn = v.dv;
        end else if (!ebusDemand && ebusXfer) begin
          if (relhi < v.h) relhi++;
          else ebusXfer = 1'b0;
        end
        if (!ebusXfer) begin
          g = {$urandom, $urandom};
          ebusDataIn = g[35:0];
        end
        tick();
      end
    end
    ebusXfer = 1'b0;
    if (fin) tick();
  endtask

  task automatic check_txn(input string tag, input vec_t v);
    int lat, dem, drvc;
    logic [35:0] dd;
    logic tmo, hold_ok;
    run_txn(v, lat, dem, drvc, dd, tmo, hold_ok);
    chk({tag, " latency"}, 64'(lat), 64'(v.lat));
    chk({tag, " demand_cycles"}, 64'(dem), 64'(v.dem));
    chk({tag, " driving_cycles"}, 64'(drvc), 64'(v.drvc));
    chk({tag, " doneData"}, 64'(dd), 64'(v.dd));
    chk({tag, " doneTimeout"}, 64'(tmo), 64'(v.tmo));
    chk({tag, " bus_hold"}, 64'(hold_ok), 64'd1);
    chk({tag, " ready_after"}, 64'(reqReady), 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " reqReady"}, 64'(reqReady), 64'd1);
    chk({tag, " ctl"},
        64'({done, doneTimeout, ebusDemand, ebusReset, ebusCS, ebusFunc}),
        64'd0);
    chk({tag, " doneData"}, 64'(doneData), 64'd0);
    chk({tag, " drv"}, 64'(drv), 64'd0);
  endtask

  initial begin
    vec_t v;
    logic [63:0] g;
    int n;
    logic bad;

    tbl[0] = '{3'd0, 7'o14, 36'o123456701234, 2, 0, 36'o0,
               5, 2, 4, 36'o0, 1'b0};
    tbl[1] = '{3'd3, 7'o20, 36'o0, 1, 0, 36'o777000111222,
               4, 1, 0, 36'o777000111222, 1'b0};
    tbl[2] = '{3'd1, 7'o5, 36'o0, 0, 0, 36'o0,
               67, 64, 0, 36'o0, 1'b1};
    tbl[3] = '{3'd2, 7'o1, 36'o707070707070, 1, 2, 36'o0,
               6, 1, 5, 36'o0, 1'b0};
    tbl[4] = '{3'd5, 7'o177, 36'o0, 3, 1, 36'o42,
               7, 3, 0, 36'o42, 1'b0};
    tbl[5] = '{3'd4, 7'o40, 36'o0, 1, 0, 36'o555555555555,
               4, 1, 0, 36'o0, 1'b0};
    tbl[6] = '{3'd6, 7'o2, 36'o1, 1, 0, 36'o0,
               2, 0, 0, 36'o0, 1'b1};
    tbl[7] = '{3'd7, 7'o3, 36'o0, 1, 0, 36'o0,
               2, 0, 0, 36'o0, 1'b1};
    tbl[8] = '{3'd2, 7'o7, 36'o111111111111, 0, 0, 36'o0,
               67, 64, 66, 36'o0, 1'b1};
    tbl[9] = '{3'd3, 7'o11, 36'o0, 64, 0, 36'o246024602460,
               67, 64, 0, 36'o246024602460, 1'b0};

    CROBAR = 1'b1; reqValid = 1'b0; reqFunc = '0; reqCS = '0;
    reqData = '0; resetReq = 1'b0; ebusXfer = 1'b0; ebusDataIn = '0;
    tick();
    tick();
    chk_reset_vals("reset");
    CROBAR = 1'b0;
    tick();

    for (int i = 0; i < 10; i++)
      check_txn($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 40; i++) begin
      v.f = 3'($urandom_range(0, 7));
      v.cs = 7'($urandom);
      g = {$urandom, $urandom};
      v.wd = g[35:0];
      g = {$urandom, $urandom};
      v.dv = g[35:0];
      v.k = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      v.h = int'($urandom_range(0, 3));
      v = model(v);
      check_txn($sformatf("rnd%0d", i), v);
      n = int'($urandom_range(0, 2));
      for (int j = 0; j < n; j++) tick();
    end

    // Back-to-back: request held through done is re-accepted after one IDLE.
    reqValid = 1'b1; reqFunc = 3'd6; reqCS = 7'o1;
    tick();
    chk("b2b setup_ready", 64'(reqReady), 64'd0);
    tick();
    chk("b2b done1", 64'({done, doneTimeout}), 64'd3);
    tick();
    chk("b2b idle_ready", 64'(reqReady), 64'd1);
    tick();
    chk("b2b reaccept", 64'(reqReady), 64'd0);
    reqValid = 1'b0;
    tick();
    chk("b2b done2", 64'(done), 64'd1);
    tick();

    // resetReq wins over a simultaneous request.
    resetReq = 1'b1; reqValid = 1'b1; reqFunc = 3'd3; reqCS = 7'o3;
    tick();
    resetReq = 1'b0;
    n = 0; bad = 1'b0;
    while (ebusReset === 1'b1 && n < 40) begin
      if (reqReady !== 1'b0 || ebusDemand !== 1'b0) bad = 1'b1;
      n++;
      tick();
    end
    chk("rst pulse_width", 64'(n), 64'(RSTC));
    chk("rst no_accept", 64'(bad), 64'd0);
    chk("rst idle_ready", 64'(reqReady), 64'd1);
    tick();
    chk("rst then_setup", 64'({reqReady, ebusCS}), 64'({1'b0, 7'o3}));
    reqValid = 1'b0;
    tick();
    chk("abort in_demand", 64'(ebusDemand), 64'd1);

    // CROBAR mid-transaction: outputs clear and no done is issued.
    CROBAR = 1'b1;
    tick();
    CROBAR = 1'b0;
    chk_reset_vals("crobar");
    bad = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (done !== 1'b0 || ebusDemand !== 1'b0) bad = 1'b1;
    end
    chk("crobar no_done", 64'(bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
